// File: rtl/nebula_mem_bridge.sv
// nebula_mem_bridge
// Memory-side responder for the core's three request/acknowledge ports: the
// instruction line fetch, the data line read/write and the page-table-walker
// 64-bit read. One transaction is in flight at a time. Each transaction is
// split into 64-bit beats on a single downstream command/response bus. Each
// completed transaction returns a single acknowledge pulse with data and an
// error flag.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_*             I-line read: req/addr in, ack/data/error out
//   dmem_*             D-line read or write-back: req/we/addr/wdata in,
//                      ack/rdata/error out
//   ptw_mem_*          PTE read: req/addr in, ack/data/error out
//   mem_cmd_*          downstream beat command (valid/ready handshake)
//   mem_rsp_*          downstream beat response (valid, data, error)
module nebula_mem_bridge #(
  parameter int PADDR_WIDTH = 56,
  parameter int XLEN        = 64,
  parameter int LINE_SIZE   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imem_req,
  input  logic [PADDR_WIDTH-1:0]   imem_addr,
  output logic                     imem_ack,
  output logic [LINE_SIZE*8-1:0]   imem_data,
  output logic                     imem_error,
  input  logic                     dmem_req,
  input  logic                     dmem_we,
  input  logic [PADDR_WIDTH-1:0]   dmem_addr,
  input  logic [LINE_SIZE*8-1:0]   dmem_wdata,
  output logic                     dmem_ack,
  output logic [LINE_SIZE*8-1:0]   dmem_rdata,
  output logic                     dmem_error,
  input  logic                     ptw_mem_req,
  input  logic [PADDR_WIDTH-1:0]   ptw_mem_addr,
  output logic                     ptw_mem_ack,
  output logic [XLEN-1:0]          ptw_mem_data,
  output logic                     ptw_mem_error,
  output logic                     mem_cmd_valid,
  input  logic                     mem_cmd_ready,
  output logic                     mem_cmd_we,
  output logic [PADDR_WIDTH-1:0]   mem_cmd_addr,
  output logic [XLEN-1:0]          mem_cmd_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [XLEN-1:0]          mem_rsp_data,
  input  logic                     mem_rsp_error
);

  localparam int BEATS  = LINE_SIZE / 8;
  localparam int LINE_W = LINE_SIZE * 8;
  localparam int BW     = $clog2(BEATS);

  localparam logic [PADDR_WIDTH-1:0] LINE_MASK = ~PADDR_WIDTH'(LINE_SIZE - 1);
  localparam logic [PADDR_WIDTH-1:0] PTE_MASK  = ~PADDR_WIDTH'(7);
  localparam logic [BW-1:0]          LAST_BEAT = BW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] G_IMEM = 2'd0;
  localparam logic [1:0] G_DMEM = 2'd1;
  localparam logic [1:0] G_PTW  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [1:0]             gnt_q, gnt_d;
  logic                   we_q, we_d;
  logic [PADDR_WIDTH-1:0] base_q, base_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic                   err_q, err_d;
  // rr_last: 0 = imem was granted last, 1 = dmem was granted last
  logic                   rr_last_q, rr_last_d;
  // set for the IDLE cycle right after DONE; masks the port just acked
  logic                   acked_q, acked_d;
  logic [LINE_W-1:0]      wline_q, wline_d;
  logic [LINE_W-1:0]      imem_data_q, imem_data_d;
  logic [LINE_W-1:0]      dmem_rdata_q, dmem_rdata_d;
  logic [XLEN-1:0]        ptw_data_q, ptw_data_d;

  logic                   elig_i, elig_d, elig_p;
  logic [BW-1:0]          last_beat;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    base_d       = base_q;
    beat_d       = beat_q;
    err_d        = err_q;
    rr_last_d    = rr_last_q;
    acked_d      = 1'b0;
    wline_d      = wline_q;
    imem_data_d  = imem_data_q;
    dmem_rdata_d = dmem_rdata_q;
    ptw_data_d   = ptw_data_q;

    elig_p    = ptw_mem_req && !(acked_q && gnt_q == G_PTW);
    elig_d    = dmem_req    && !(acked_q && gnt_q == G_DMEM);
    elig_i    = imem_req    && !(acked_q && gnt_q == G_IMEM);
    last_beat = (gnt_q == G_PTW) ? '0 : LAST_BEAT;

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        err_d  = 1'b0;
        if (elig_p) begin
          gnt_d      = G_PTW;
          we_d       = 1'b0;
          base_d     = ptw_mem_addr & PTE_MASK;
          ptw_data_d = '0;
          state_d    = S_CMD;
        end else if (elig_d && (!elig_i || !rr_last_q)) begin
          gnt_d     = G_DMEM;
          we_d      = dmem_we;
          base_d    = dmem_addr & LINE_MASK;
          rr_last_d = 1'b1;
          state_d   = S_CMD;
          // a write-back leaves the previous read line visible
          if (dmem_we) wline_d = dmem_wdata;
          else         dmem_rdata_d = '0;
        end else if (elig_i) begin
          gnt_d       = G_IMEM;
          we_d        = 1'b0;
          base_d      = imem_addr & LINE_MASK;
          rr_last_d   = 1'b0;
          imem_data_d = '0;
          state_d     = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error) begin
            // abort: the failing beat and the rest stay zero
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            if (!we_q) begin
              if (gnt_q == G_PTW) begin
                ptw_data_d = mem_rsp_data;
              end else begin
                for (int i = 0; i < BEATS; i++) begin
                  if (beat_q == BW'(i)) begin
                    if (gnt_q == G_IMEM) imem_data_d[i*XLEN +: XLEN] = mem_rsp_data;
                    else                 dmem_rdata_d[i*XLEN +: XLEN] = mem_rsp_data;
                  end
                end
              end
            end
            if (beat_q == last_beat) begin
              state_d = S_DONE;
            end else begin
              beat_d  = beat_q + 1'b1;
              state_d = S_CMD;
            end
          end
        end
      end
      default: begin
        acked_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      gnt_q        <= G_IMEM;
      we_q         <= 1'b0;
      base_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      rr_last_q    <= 1'b0;
      acked_q      <= 1'b0;
      wline_q      <= '0;
      imem_data_q  <= '0;
      dmem_rdata_q <= '0;
      ptw_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      rr_last_q    <= rr_last_d;
      acked_q      <= acked_d;
      wline_q      <= wline_d;
      imem_data_q  <= imem_data_d;
      dmem_rdata_q <= dmem_rdata_d;
      ptw_data_q   <= ptw_data_d;
    end
  end

  always_comb begin
    mem_cmd_valid = (state_q == S_CMD);
    mem_cmd_we    = mem_cmd_valid && we_q;
    mem_cmd_addr  = '0;
    mem_cmd_wdata = '0;
    if (mem_cmd_valid) begin
      mem_cmd_addr = base_q + {{(PADDR_WIDTH-BW-3){1'b0}}, beat_q, 3'b000};
      if (we_q) begin
        for (int i = 0; i < BEATS; i++) begin
          if (beat_q == BW'(i)) mem_cmd_wdata = wline_q[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign imem_ack      = (state_q == S_DONE) && (gnt_q == G_IMEM);
  assign dmem_ack      = (state_q == S_DONE) && (gnt_q == G_DMEM);
  assign ptw_mem_ack   = (state_q == S_DONE) && (gnt_q == G_PTW);
  assign imem_error    = imem_ack && err_q;
  assign dmem_error    = dmem_ack && err_q;
  assign ptw_mem_error = ptw_mem_ack && err_q;
  assign imem_data     = imem_data_q;
  assign dmem_rdata    = dmem_rdata_q;
  assign ptw_mem_data  = ptw_data_q;

endmodule

// File: tb/tb_nebula_mem_bridge.sv
module tb_nebula_mem_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req;
  logic [55:0]  imem_addr;
  logic         imem_ack;
  logic [511:0] imem_data;
  logic         imem_error;
  logic         dmem_req;
  logic         dmem_we;
  logic [55:0]  dmem_addr;
  logic [511:0] dmem_wdata;
  logic         dmem_ack;
  logic [511:0] dmem_rdata;
  logic         dmem_error;
  logic         ptw_mem_req;
  logic [55:0]  ptw_mem_addr;
  logic         ptw_mem_ack;
  logic [63:0]  ptw_mem_data;
  logic         ptw_mem_error;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_we;
  logic [55:0]  mem_cmd_addr;
  logic [63:0]  mem_cmd_wdata;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;
  logic         mem_rsp_error;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;

  nebula_mem_bridge #(.PADDR_WIDTH(56), .XLEN(64), .LINE_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_error(imem_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_error(dmem_error),
    .ptw_mem_req(ptw_mem_req), .ptw_mem_addr(ptw_mem_addr),
    .ptw_mem_ack(ptw_mem_ack), .ptw_mem_data(ptw_mem_data),
    .ptw_mem_error(ptw_mem_error),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_cmd_wdata(mem_cmd_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_error(mem_rsp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays the downstream side of one beat: waits for the command, optionally
  // stalls ready, accepts, then answers on the next cycle unless no_rsp.
  task automatic serve(input logic [55:0] ea, input logic ewe, input logic [63:0] ewd,
                       input logic [63:0] rd, input logic rerr, input int stall,
                       input bit no_rsp);
    int n;
    n = 0;
    while (mem_cmd_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("cmd_seen", mem_cmd_valid, 1'b1);
    chk("cmd_addr", mem_cmd_addr, ea);
    chk("cmd_we", mem_cmd_we, ewe);
    if (ewe) chk("cmd_wdata", mem_cmd_wdata, ewd);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", mem_cmd_valid, 1'b1);
      chk("stall_addr", mem_cmd_addr, ea);
      chk("stall_wdata", mem_cmd_wdata, ewd);
    end
    mem_cmd_ready = 1'b1;
    tick();
    mem_cmd_ready = 1'b0;
    chk("cmd_dropped", mem_cmd_valid, 1'b0);
    if (!no_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rd;
      mem_rsp_error = rerr;
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      mem_rsp_error = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req = 0; imem_addr = '0;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wdata = '0;
    ptw_mem_req = 0; ptw_mem_addr = '0;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; mem_rsp_error = 0;
    tick(); tick();
    chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
    chk("rst_cmd_addr", mem_cmd_addr, 56'h0);
    chk("rst_acks", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    chk("rst_imem_data", imem_data, 512'h0);
    chk("rst_ptw_data", ptw_mem_data, 64'h0);
    rst_n = 1'b1;
    tick();

    // PTW read, unaligned PTE address
    ptw_mem_addr = 56'h8000_1004; ptw_mem_req = 1; t0 = cyc;
    serve(56'h8000_1000, 0, 64'h0, 64'h0000_0000_2000_0C01, 0, 0, 0);
    chk("ptw_ack", ptw_mem_ack, 1'b1);
    chk("ptw_latency", cyc - t0, 3);
    chk("ptw_data", ptw_mem_data, 64'h2000_0C01);
    chk("ptw_error", ptw_mem_error, 1'b0);
    chk("ptw_other_acks", {imem_ack, dmem_ack}, 2'b00);
    ptw_mem_req = 0;
    tick();
    chk("ptw_ack_pulse", ptw_mem_ack, 1'b0);

    // imem line read, address inside the line
    imem_addr = 56'h8000_0020; imem_req = 1; t0 = cyc;
    for (int k = 0; k < 8; k++)
      serve(56'h8000_0000 + 56'(8*k), 0, 64'h0, 64'(8'h11 * (k+1)), 0, 0, 0);
    chk("imem_ack", imem_ack, 1'b1);
    chk("imem_latency", cyc - t0, 17);
    chk("imem_beat0", imem_data[63:0], 64'h11);
    chk("imem_beat7", imem_data[511:448], 64'h88);
    chk("imem_error", imem_error, 1'b0);
    imem_req = 0;
    tick();

    // all three at once: ptw, then dmem, then imem, then dmem again
    ptw_mem_addr = 56'h100; dmem_addr = 56'h2000; imem_addr = 56'h3000;
    ptw_mem_req = 1; dmem_req = 1; imem_req = 1;
    serve(56'h100, 0, 64'h0, 64'hABCD, 0, 0, 0);
    chk("arb_ptw_ack", ptw_mem_ack, 1'b1);
    chk("arb_ptw_data", ptw_mem_data, 64'hABCD);
    ptw_mem_req = 0;
    for (int k = 0; k < 8; k++)
      serve(56'h2000 + 56'(8*k), 0, 64'h0, 64'(8'hD0 + k), 0, 0, 0);
    chk("arb_dmem_ack", dmem_ack, 1'b1);
    chk("arb_dmem_beat1", dmem_rdata[127:64], 64'hD1);
    for (int k = 0; k < 8; k++)
      serve(56'h3000 + 56'(8*k), 0, 64'h0, 64'(8'hE0 + k), 0, 0, 0);
    chk("arb_imem_ack", imem_ack, 1'b1);
    chk("arb_imem_beat7", imem_data[511:448], 64'hE7);
    for (int k = 0; k < 8; k++)
      serve(56'h2000 + 56'(8*k), 0, 64'h0, 64'(8'hF0 + k), 0, 0, 0);
    chk("arb_dmem2_ack", dmem_ack, 1'b1);
    chk("arb_dmem2_beat0", dmem_rdata[63:0], 64'hF0);
    dmem_req = 0; imem_req = 0;
    tick();

    // dmem write-back with ready stalled on beat 2
    dmem_we = 1; dmem_addr = 56'h9000_0040;
    for (int k = 0; k < 8; k++) dmem_wdata[k*64 +: 64] = 64'(k + 1);
    dmem_req = 1;
    for (int k = 0; k < 8; k++)
      serve(56'h9000_0040 + 56'(8*k), 1, 64'(k + 1), 64'h0, 0, (k == 2) ? 3 : 0, 0);
    chk("wr_ack", dmem_ack, 1'b1);
    chk("wr_error", dmem_error, 1'b0);
    chk("wr_rdata_kept", dmem_rdata[511:448], 64'hF7);
    dmem_req = 0; dmem_we = 0;
    tick();
    chk("wr_ack_pulse", dmem_ack, 1'b0);

    // imem read, error on beat 3
    imem_addr = 56'h4000; imem_req = 1;
    for (int k = 0; k < 3; k++)
      serve(56'h4000 + 56'(8*k), 0, 64'h0, 64'(8'hA0 + k), 0, 0, 0);
    serve(56'h4018, 0, 64'h0, 64'hBAD, 1, 0, 0);
    chk("err_ack", imem_ack, 1'b1);
    chk("err_flag", imem_error, 1'b1);
    chk("err_no_beat4", mem_cmd_valid, 1'b0);
    chk("err_slice0", imem_data[63:0], 64'hA0);
    chk("err_slice2", imem_data[191:128], 64'hA2);
    chk("err_slice3", imem_data[255:192], 64'h0);
    chk("err_slice7", imem_data[511:448], 64'h0);
    tick();
    tick();
    chk("mask_no_regrant", mem_cmd_valid, 1'b0);
    imem_req = 0;
    tick();

    // reset during beat 5 of a dmem read
    dmem_addr = 56'h5000; dmem_req = 1;
    for (int k = 0; k < 5; k++)
      serve(56'h5000 + 56'(8*k), 0, 64'h0, 64'(8'h50 + k), 0, 0, 0);
    serve(56'h5028, 0, 64'h0, 64'h0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_imem_data", imem_data, 512'h0);
    chk("arst_dmem_rdata", dmem_rdata, 512'h0);
    chk("arst_acks", {imem_ack, dmem_ack, ptw_mem_ack}, 3'b000);
    chk("arst_cmd_valid", mem_cmd_valid, 1'b0);
    dmem_req = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_no_ack", dmem_ack, 1'b0);
    end

    // service resumes normally
    ptw_mem_addr = 56'h8000_2008; ptw_mem_req = 1; t0 = cyc;
    serve(56'h8000_2008, 0, 64'h0, 64'h1234, 0, 0, 0);
    chk("resume_ack", ptw_mem_ack, 1'b1);
    chk("resume_latency", cyc - t0, 3);
    chk("resume_data", ptw_mem_data, 64'h1234);
    ptw_mem_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
